// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND scan controller: iterative binary-to-BCD conversion on load,
// then time-multiplexed digit select with guard band and leading-zero blanking.
module fnd_scan_ctrl #(
   parameter int DIV_COUNT    = 100000,
   parameter int GUARD_CYCLES = 2,
   parameter int BLANK_LZ     = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [13:0] i_value,
   input  logic        i_load,
   output logic        o_busy,
   output logic [1:0]  o_digit_idx,
   output logic        o_digit_off,
   output logic [3:0]  o_bcd
);

   localparam int              PW         = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV_COUNT - 1);
   localparam logic [13:0]     MAX_VALUE  = 14'd9999;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t        state_reg, state_next;
   logic [13:0]   bin_reg, bin_next;
   logic [15:0]   acc_reg, acc_next, acc_adj;
   logic [3:0]    iter_reg, iter_next;
   logic [15:0]   disp_reg, disp_next;
   logic          busy_next;

   logic [PW-1:0] presc_reg, presc_next;
   logic [1:0]    idx_next;
   logic [3:0]    blank;
   logic          in_guard;

   // Double-dabble add-3 correction on every BCD nibble before the shift
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_adj
         assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                     acc_reg[4*gi +: 4] + 4'd3 : acc_reg[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      bin_next   = bin_reg;
      acc_next   = acc_reg;
      iter_next  = iter_reg;
      disp_next  = disp_reg;
      case (state_reg)
         IDLE: begin
            if (i_load) begin
               bin_next   = (i_value > MAX_VALUE) ? MAX_VALUE : i_value;
               acc_next   = '0;
               iter_next  = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            {acc_next, bin_next} = {acc_adj[14:0], bin_reg, 1'b0};
            iter_next = iter_reg + 4'd1;
            if (iter_reg == 4'd13)
               state_next = COMMIT;
         end
         COMMIT: begin
            disp_next  = acc_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next != IDLE);
   end

   always_comb begin
      if (presc_reg == PRESC_LAST) begin
         presc_next = '0;
         idx_next   = o_digit_idx + 2'd1;
      end else begin
         presc_next = presc_reg + 1'b1;
         idx_next   = o_digit_idx;
      end
   end

   // Digit k is dark when it and every more significant nibble are zero
   assign blank[0] = 1'b0;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_blank
         assign blank[gi] = (BLANK_LZ != 0) && (disp_reg[15:4*gi] == '0);
      end
      if (GUARD_CYCLES > 0) begin : g_guard
         assign in_guard = (presc_next < PW'(GUARD_CYCLES));
      end else begin : g_noguard
         assign in_guard = 1'b0;
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg   <= IDLE;
         bin_reg     <= '0;
         acc_reg     <= '0;
         iter_reg    <= '0;
         disp_reg    <= '0;
         presc_reg   <= '0;
         o_busy      <= 1'b0;
         o_digit_idx <= 2'd0;
         o_digit_off <= 1'b1;
         o_bcd       <= 4'd0;
      end else begin
         state_reg   <= state_next;
         bin_reg     <= bin_next;
         acc_reg     <= acc_next;
         iter_reg    <= iter_next;
         disp_reg    <= disp_next;
         presc_reg   <= presc_next;
         o_busy      <= busy_next;
         o_digit_idx <= idx_next;
         o_digit_off <= in_guard || blank[idx_next];
         o_bcd       <= disp_reg[{idx_next, 2'b00} +: 4];
      end
   end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: a decimal-arithmetic display model
// plus a free-running cycle count predicts idx/off/bcd on every checked cycle.
module tb_fnd_scan_ctrl;

   localparam int DIV   = 8;
   localparam int GUARD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] value = '0;
   logic        load = 1'b0;
   logic        busy;
   logic [1:0]  idx;
   logic        off;
   logic [3:0]  bcd;

   int errors = 0;
   int checks = 0;
   int t;

   fnd_scan_ctrl #(.DIV_COUNT(DIV), .GUARD_CYCLES(GUARD), .BLANK_LZ(1)) dut (
      .i_clk(clk), .i_reset(rst), .i_value(value), .i_load(load),
      .o_busy(busy), .o_digit_idx(idx), .o_digit_off(off), .o_bcd(bcd)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release: slot position and digit follow from it
   always @(posedge clk or posedge rst) begin
      if (rst) t <= 0;
      else     t <= t + 1;
   end

   function automatic int sat(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   function automatic int exp_idx(input int tt);
      return (tt / DIV) % 4;
   endfunction

   function automatic int exp_bcd(input int v, input int tt);
      return (sat(v) / pow10(exp_idx(tt))) % 10;
   endfunction

   function automatic bit exp_off(input int v, input int tt);
      int k = exp_idx(tt);
      return ((tt % DIV) < GUARD) || (k != 0 && sat(v) < pow10(k));
   endfunction

   task automatic pulse_load(input int v);
      @(posedge clk);
      #1 value = 14'(v); load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   // Counts busy cycles until busy drops; returns at the first negedge with busy=0
   task automatic wait_idle(output int n);
      bit done = 0;
      n = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (busy) n++;
         else      done = 1;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || idx !== 2'd0 || off !== 1'b1 || bcd !== 4'd0) begin
         errors++;
         $display("FAIL reset_hold got busy=%0b idx=%0d off=%0b bcd=%0d want 0/0/1/0", busy, idx, off, bcd);
      end
      rst = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         checks++;
         if (idx !== 2'(exp_idx(t)) || off !== exp_off(0, t) || bcd !== 4'(exp_bcd(0, t))) begin
            errors++;
            $display("FAIL reset_scan t=%0d got idx=%0d off=%0b bcd=%0d want %0d/%0b/%0d",
                     t, idx, off, bcd, exp_idx(t), exp_off(0, t), exp_bcd(0, t));
         end
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || idx !== 2'd0 || off !== 1'b1 || bcd !== 4'd0) begin
         errors++;
         $display("FAIL reset_async got busy=%0b idx=%0d off=%0b bcd=%0d want 0/0/1/0", busy, idx, off, bcd);
      end
      @(negedge clk);
      rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_load_display(input int v);
      int n;
      pulse_load(v);
      wait_idle(n);
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL busy_len value=%0d got %0d want 15", v, n);
      end
      @(posedge clk);
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         checks++;
         if (idx !== 2'(exp_idx(t)) || off !== exp_off(v, t) || bcd !== 4'(exp_bcd(v, t))) begin
            errors++;
            $display("FAIL scan value=%0d t=%0d got idx=%0d off=%0b bcd=%0d want %0d/%0b/%0d",
                     v, t, idx, off, bcd, exp_idx(t), exp_off(v, t), exp_bcd(v, t));
         end
      end
      $display("test_load_display value=%0d done", v);
   endtask

   task automatic test_back_to_back();
      int n;
      pulse_load(5555);
      @(posedge clk);
      @(posedge clk);
      #1 value = 14'd42; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      wait_idle(n);
      checks++;
      if (n + 3 != 15) begin
         errors++;
         $display("FAIL ignore_busy_len got %0d want 15", n + 3);
      end
      @(posedge clk);
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         checks++;
         if (off !== exp_off(5555, t) || bcd !== 4'(exp_bcd(5555, t))) begin
            errors++;
            $display("FAIL ignore_scan t=%0d got off=%0b bcd=%0d want %0b/%0d",
                     t, off, bcd, exp_off(5555, t), exp_bcd(5555, t));
         end
      end
      pulse_load(300);
      wait_idle(n);
      value = 14'd42; load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL accept_on_fall got busy=%0b want 1", busy);
      end
      wait_idle(n);
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL accept_busy_len got %0d want 15", n);
      end
      @(posedge clk);
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         checks++;
         if (off !== exp_off(42, t) || bcd !== 4'(exp_bcd(42, t))) begin
            errors++;
            $display("FAIL accept_scan t=%0d got off=%0b bcd=%0d want %0b/%0d",
                     t, off, bcd, exp_off(42, t), exp_bcd(42, t));
         end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid_conversion();
      int n;
      pulse_load(8888);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || idx !== 2'd0 || off !== 1'b1 || bcd !== 4'd0) begin
         errors++;
         $display("FAIL midconv_reset got busy=%0b idx=%0d off=%0b bcd=%0d want 0/0/1/0", busy, idx, off, bcd);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || off !== exp_off(0, t) || bcd !== 4'(exp_bcd(0, t))) begin
            errors++;
            $display("FAIL midconv_scan t=%0d got busy=%0b off=%0b bcd=%0d want 0/%0b/%0d",
                     t, busy, off, bcd, exp_off(0, t), exp_bcd(0, t));
         end
      end
      pulse_load(31);
      wait_idle(n);
      checks++;
      if (n != 15) begin
         errors++;
         $display("FAIL midconv_busy_len got %0d want 15", n);
      end
      @(posedge clk);
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         checks++;
         if (off !== exp_off(31, t) || bcd !== 4'(exp_bcd(31, t))) begin
            errors++;
            $display("FAIL midconv_31 t=%0d got off=%0b bcd=%0d want %0b/%0d",
                     t, off, bcd, exp_off(31, t), exp_bcd(31, t));
         end
      end
      $display("test_reset_mid_conversion done");
   endtask

   task automatic test_random();
      int v;
      int n;
      for (int r = 0; r < 8; r++) begin
         v = $urandom_range(0, 16383);
         pulse_load(v);
         wait_idle(n);
         checks++;
         if (n != 15) begin
            errors++;
            $display("FAIL rand_busy_len value=%0d got %0d want 15", v, n);
         end
         @(posedge clk);
         for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            checks++;
            if (idx !== 2'(exp_idx(t)) || off !== exp_off(v, t) || bcd !== 4'(exp_bcd(v, t))) begin
               errors++;
               $display("FAIL rand_scan value=%0d t=%0d got idx=%0d off=%0b bcd=%0d want %0d/%0b/%0d",
                        v, t, idx, off, bcd, exp_idx(t), exp_off(v, t), exp_bcd(v, t));
            end
         end
         $display("test_random value=%0d done", v);
      end
   endtask

   initial begin
      test_reset();
      test_load_display(1234);
      test_load_display(7);
      test_load_display(105);
      test_load_display(0);
      test_load_display(12000);
      test_load_display(9009);
      test_back_to_back();
      test_reset_mid_conversion();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
